sum_accum: RTL and testbench

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum_pkg.sv | 16 +
 rtl/sum_accum_ripple_adder.sv | 22 ++
 rtl/sum_accum.sv | 114 +++++++++++
 tb/tb_sum_accum.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and defaults for the sum_accum burst accumulator.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_MAX_LEN = 16;

  localparam logic [DEF_WIDTH-1:0] SAT_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/sum_accum_ripple_adder.sv
// Plain ripple-carry adder: sum and carry-out, no carry-in.
module ripple_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/sum_accum.sv
// Burst accumulator: sums len operands, reports sticky carry/overflow.
// Optional saturation on signed overflow via macro SUM_ACCUM_SAT_EN.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_sum,
  output logic                           out_carry,
  output logic                           out_overflow,
  output logic                           busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [LW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_cout;
  logic             w_ovf;
  logic             w_beat;
  logic             w_start_ok;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (r_acc),
    .b    (in_data),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_ovf = (r_acc[WIDTH-1] == in_data[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

`ifdef SUM_ACCUM_SAT_EN
  localparam logic [WIDTH-1:0] L_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] L_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  // Overflow only occurs with equal operand signs, so acc's MSB picks the rail.
  assign w_acc_nxt = w_ovf ? (r_acc[WIDTH-1] ? L_SAT_NEG : L_SAT_POS) : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  assign w_start_ok = (r_state == IDLE) && start && (len != '0) && (len <= LW'(MAX_LEN));
  assign w_beat     = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == LW'(1))) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_start_ok) begin
      r_acc   <= '0;
      r_cnt   <= len;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_beat) begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= r_cnt - LW'(1);
      r_carry <= r_carry | w_cout;
      r_ovf   <= r_ovf | w_ovf;
    end
  end

  assign out_sum      = r_acc;
  assign out_carry    = r_carry;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum; expectations follow SUM_ACCUM_SAT_EN if defined.
module tb_sum_accum;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LW-1:0]    len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic             busy;

  int checks = 0;
  int errors = 0;

  sum_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [LW-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_flags", {out_carry, out_overflow}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Positive overflow: 0x7fffffff + 1
    start_burst(2);
    check("p_busy", busy, 1);
    check("p_in_ready", in_ready, 1);
    beat(32'h7fff_ffff);
    check("p_not_done", out_valid, 0);
    beat(32'h0000_0001);
    check("p_out_valid", out_valid, 1);
`ifdef SUM_ACCUM_SAT_EN
    check("p_sum", out_sum, 32'h7fff_ffff);
`else
    check("p_sum", out_sum, 32'h8000_0000);
`endif
    check("p_ovf", out_overflow, 1);
    check("p_carry", out_carry, 0);
    check("p_in_ready_done", in_ready, 0);
    handshake();
    check("p_idle_busy", busy, 0);
    check("p_idle_valid", out_valid, 0);

    // Negative overflow with carry: 0xffffffff + 0x80000000
    start_burst(2);
    beat(32'hffff_ffff);
    check("n_first_sum", out_sum, 32'hffff_ffff);
    check("n_first_ovf", out_overflow, 0);
    beat(32'h8000_0000);
`ifdef SUM_ACCUM_SAT_EN
    check("n_sum", out_sum, 32'h8000_0000);
`else
    check("n_sum", out_sum, 32'h7fff_ffff);
`endif
    check("n_ovf", out_overflow, 1);
    check("n_carry", out_carry, 1);
    handshake();

    // Gapped burst; flags from previous burst must be cleared
    start_burst(3);
    check("g_flags_clr", {out_carry, out_overflow}, 0);
    beat(32'h0000_0002);
    start = 1'b1;
    len   = 1;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    check("g_gap_sum", out_sum, 32'h0000_0002);
    check("g_gap_ready", in_ready, 1);
    @(negedge clk);
    check("g_gap_sum2", out_sum, 32'h0000_0002);
    beat(32'hffff_fffb);
    check("g_mid_sum", out_sum, 32'hffff_fffd);
    @(negedge clk);
    @(negedge clk);
    check("g_before_last", out_valid, 0);
    beat(32'h0000_000c);
    check("g_valid_latency", out_valid, 1);
    check("g_sum", out_sum, 32'h0000_0009);
    check("g_carry", out_carry, 1);
    check("g_ovf", out_overflow, 0);

    // Backpressure in DONE while pulsing start
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 1;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 32'h0000_0009);
      check("bp_in_ready", in_ready, 0);
    end
    start = 1'b0;
    len   = '0;
    handshake();
    check("bp_busy_after", busy, 0);
    @(negedge clk);
    check("bp_no_restart", busy, 0);

    // Reset mid-burst
    start_burst(3);
    beat(32'h0000_0005);
    check("r_partial", out_sum, 32'h0000_0005);
    rst_n = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_sum", out_sum, 0);
    check("r_ready", in_ready, 0);
    check("r_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("r_idle", busy, 0);
    start_burst(1);
    beat(32'h0000_000a);
    check("r2_valid", out_valid, 1);
    check("r2_sum", out_sum, 32'h0000_000a);
    check("r2_flags", {out_carry, out_overflow}, 0);
    handshake();

    // Illegal lengths are ignored
    start_burst(0);
    check("l0_busy", busy, 0);
    check("l0_ready", in_ready, 0);
    start_burst(LW'(MAX_LEN + 1));
    check("lmax_busy", busy, 0);
    check("lmax_ready", in_ready, 0);

    // Maximum legal length accepted
    start_burst(LW'(MAX_LEN));
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      beat(32'h0000_0003);
    end
    check("max_valid", out_valid, 1);
    check("max_sum", out_sum, 32'h0000_0030);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
